// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch unit with one-entry buffer
// Handles redirects (branch, flush) and drops stale read data after a flush.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  input  logic        stall_i,
  input  logic        PCSel_i,
  input  logic [31:0] target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic        r_discard;
  logic [31:0] r_fetch_pc;
  logic        r_req;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  logic [31:0] w_flush_pc;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic        w_consume;

  assign w_flush_pc = flush_pc_i & ~32'h3;
  assign w_target   = target_i & ~32'h3;
  assign w_next_pc  = r_fetch_pc + 32'd4;
  assign w_consume  = r_valid & ~stall_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_discard  <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_inst     <= NOP;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
    end else if (flush_i) begin
      // Flush beats any branch; an in-flight or just-granted request must be drained.
      r_fetch_pc <= w_flush_pc;
      r_valid    <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (imem_rvalid_i) begin
            r_state   <= S_REQ;
            r_req     <= 1'b1;
            r_discard <= 1'b0;
          end else begin
            r_state   <= S_WAIT;
            r_req     <= 1'b0;
            r_discard <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_gnt_i) begin
            r_state   <= S_WAIT;
            r_req     <= 1'b0;
            r_discard <= 1'b1;
          end else begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          if (imem_gnt_i) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
              r_req     <= 1'b1;
            end else begin
              r_inst     <= imem_rdata_i;
              r_pc       <= r_fetch_pc;
              r_valid    <= 1'b1;
              r_fetch_pc <= w_next_pc;
              r_state    <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (w_consume) begin
            r_valid <= 1'b0;
            r_state <= S_REQ;
            r_req   <= 1'b1;
            if (PCSel_i) begin
              r_fetch_pc <= w_target;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o   = r_req;
  assign imem_addr_o  = r_fetch_pc;
  assign inst_o       = r_inst;
  assign pc_o         = r_pc;
  assign inst_valid_o = r_valid;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port imem_req_o  output  1  instruction-memory request valid.
REQ-005 SHALL have port imem_addr_o  output  32  request address, bits [1:0] always 00.
REQ-006 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-007 SHALL have port imem_rvalid_i  input  1  read data valid.
REQ-008 SHALL have port imem_rdata_i  input  32  read data.
REQ-009 SHALL have port inst_o  output  32  buffered instruction to Control_Logic inst_i.
REQ-010 SHALL have port pc_o  output  32  address of inst_o.
REQ-011 SHALL have port inst_valid_o  output  1  inst_o/pc_o hold a live instruction.
REQ-012 SHALL have port stall_i  input  1  downstream hold; instruction consumed when inst_valid_o & ~stall_i.
REQ-013 SHALL have port PCSel_i  input  1  taken branch/jump from Control_Logic PCSel_o.
REQ-014 SHALL have port target_i  input  32  redirect target (ALU result).
REQ-015 SHALL have port flush_i  input  1  unconditional redirect, valid in any state.
REQ-016 SHALL have port flush_pc_i  input  32  flush target.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT, FULL plus a 1-bit discard flag and a 32-bit fetch_pc register.
REQ-018 IDLE: outputs quiet; SHALL go to REQ next cycle.
REQ-019 REQ: imem_req_o=1, imem_addr_o=fetch_pc; imem_gnt_i=1 -> WAIT; else remain REQ; address may change while ungranted only on flush.
REQ-020 WAIT: imem_req_o=0; imem_rvalid_i=1 with discard=0 -> load inst_o=imem_rdata_i, pc_o=fetch_pc, inst_valid_o=1, fetch_pc+=4, go FULL.
REQ-021 WAIT: imem_rvalid_i=1 with discard=1 -> drop data, clear discard, go REQ; inst_valid_o stays 0.
REQ-022 FULL: inst_valid_o=1, inst_o/pc_o stable while stall_i=1; consume without PCSel_i -> inst_valid_o=0, go REQ at fetch_pc.
REQ-023 FULL: consume with PCSel_i=1 -> fetch_pc={target_i[31:2],2'b00}, inst_valid_o=0, go REQ; PCSel_i SHALL be ignored unless inst_valid_o & ~stall_i.
REQ-024 flush_i=1 in any state SHALL set fetch_pc={flush_pc_i[31:2],2'b00} and inst_valid_o=0 next cycle.
REQ-025 flush_i in IDLE/FULL/REQ-without-gnt -> REQ; flush_i in WAIT, or in REQ coincident with imem_gnt_i -> WAIT with discard=1.
REQ-026 flush_i and PCSel_i in same cycle: flush_i SHALL win.
REQ-027 flush_i in WAIT coincident with imem_rvalid_i: data dropped, discard stays 0, go REQ.
REQ-028 imem_rvalid_i outside WAIT SHALL be ignored; at most one request outstanding.
REQ-029 fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 Latency: gnt in cycle N, rvalid in N+k -> inst_valid_o high from N+k+1; peak one instruction per 3 cycles.

Reset
REQ-031 rst_ni=0 at a clock edge SHALL force state=IDLE, fetch_pc=RESET_PC, discard=0, imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=32'h0000_0013 (NOP), pc_o=RESET_PC.
REQ-032 Reset mid-transaction SHALL abandon the outstanding request; any later imem_rvalid_i before a new grant is ignored.

Verification
REQ-033 Reset release, gnt immediate, rvalid next cycle rdata=32'h00500093 -> addr 0 requested, inst_o=32'h00500093, pc_o=0, inst_valid_o=1; next request addr 4.
REQ-034 FULL with stall_i=1 for 5 cycles -> inst_o/pc_o unchanged, imem_req_o=0; stall_i=0 -> request at pc_o+4.
REQ-035 FULL pc_o=8, PCSel_i=1, target_i=32'h0000_0103 -> next request addr 32'h0000_0100.
REQ-036 WAIT for addr 4, flush_i=1 flush_pc_i=32'h80 -> returned data dropped, inst_valid_o stays 0, next request addr 32'h80.
REQ-037 flush_i and PCSel_i together, flush_pc_i=32'h40, target_i=32'h200 -> next request addr 32'h40.
REQ-038 RESET_PC=32'hFFFF_FFFC, fetch one instruction -> next request addr 32'h0000_0000.
